ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between N requesters using a rotating one-hot token. The token rotation matches the team's 4-bit ring counter: 1000 → 0100 → 0010 → 0001 → 1000. The block issues one-hot grants, enforces a maximum hold time, and inserts a fixed turnaround gap between grants. It sits in front of any shared datapath resource, for example a ring-counter-driven shared register, and gives one requester access at a time.

---
 rtl/ring_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 37 +++
 rtl/ring_arbiter.sv | 110 +++++++++++
 tb/tb_ring_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package ring_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Widest ring the rotate helper supports; callers zero-extend and slice.
  localparam int unsigned MaxN = 32;
  localparam int unsigned MaxW = $clog2(MaxN);

  // Rotate the low n bits of v right by one: bit i -> bit i-1, bit 0 -> bit n-1.
  function automatic logic [MaxN-1:0] rotate_right(input logic [MaxN-1:0] v,
                                                   input int unsigned     n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < MaxN; i++) begin
      if (i < n) r[MaxW'(i - 1)] = v[MaxW'(i)];
    end
    r[MaxW'(n - 1)] = v[0];
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req from the token bit downward,
// wrapping from bit 0 to bit N-1; the first set bit wins.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] token,
  output logic [N-1:0] winner
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] tidx;
  logic [IdxW-1:0] idx;
  logic            found;

  // Locate the token, then walk downward from it to the first requester.
  always_comb begin
    tidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (token[i]) tidx = IdxW'(i);
    end
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(tidx) + N - k) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot token, a hold-time limit and a
// one-cycle dead gap after every grant. All outputs come straight from flops.
module ring_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned HOLD_W   = $clog2(HOLD_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      done,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      token,
  output logic              busy,
  output logic              timeout,
  output logic [HOLD_W-1:0] hold_cnt
);

  state_e              state_q;
  logic [N-1:0]        gnt_q;
  logic [N-1:0]        token_q;
  logic                busy_q;
  logic                timeout_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  logic [N-1:0]        winner;
  logic [MaxN-1:0]     rot_full;
  logic [N-1:0]        token_rot;
  logic                unused_rot_hi;
  logic                done_g;
  logic                req_g;
  logic                at_limit;
  logic                release_g;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .token  (token_q),
    .winner (winner)
  );

  // Next token is the current grant rotated one place toward bit 0.
  always_comb begin
    rot_full      = rotate_right(MaxN'(gnt_q), N);
    token_rot     = rot_full[N-1:0];
    unused_rot_hi = ^rot_full[MaxN-1:N];
  end

  // Release conditions seen through the one-hot grant mask.
  always_comb begin
    done_g    = |(done & gnt_q);
    req_g     = |(req & gnt_q);
    at_limit  = (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));
    release_g = done_g | ~req_g | at_limit;
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      token_q    <= {1'b1, {(N - 1){1'b0}}};
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q    <= GRANT;
            gnt_q      <= winner;
            hold_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        GRANT: begin
          if (release_g) begin
            state_q   <= GAP;
            gnt_q     <= '0;
            token_q   <= token_rot;
            // Only a pure hold-limit revocation counts as a timeout.
            timeout_q <= at_limit & ~done_g & req_g;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign token    = token_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Randomized bench for ring_arbiter: a cycle-level reference model pushes the
// expected outputs into a queue; a monitor pops and compares after each edge.
module tb_ring_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
  localparam int HOLD_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      done;
  logic [N-1:0]      gnt;
  logic [N-1:0]      token;
  logic              busy;
  logic              timeout;
  logic [HOLD_W-1:0] hold_cnt;

  always #5 clk = ~clk;

  ring_arbiter #(
    .N        (N),
    .HOLD_MAX (HOLD_MAX),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .token    (token),
    .busy     (busy),
    .timeout  (timeout),
    .hold_cnt (hold_cnt)
  );

  typedef struct {
    logic [N-1:0]      gnt;
    logic [N-1:0]      token;
    logic              busy;
    logic              timeout;
    logic [HOLD_W-1:0] hold;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  // Reference model: owner index (-1 = none), pointer index, grant age, gap flag.
  int owner   = -1;
  int ptr     = N - 1;
  int age     = 0;
  bit in_gap  = 1'b0;
  bit to_flag = 1'b0;

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d,
                                     input logic rs);
    bit lim;
    if (!rs) begin
      owner = -1; ptr = N - 1; age = 0; in_gap = 1'b0; to_flag = 1'b0;
    end else if (owner >= 0) begin
      lim     = (age == HOLD_MAX - 1);
      to_flag = 1'b0;
      if (d[owner] || !r[owner] || lim) begin
        to_flag = lim && !d[owner] && r[owner];
        ptr     = (owner - 1 + N) % N;
        owner   = -1;
        in_gap  = 1'b1;
      end else begin
        age++;
      end
    end else if (in_gap) begin
      in_gap  = 1'b0;
      to_flag = 1'b0;
    end else begin
      to_flag = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr - k + N) % N;
        if (r[i]) begin
          owner = i;
          age   = 0;
          break;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt     = (owner >= 0) ? (N'(1) << owner) : '0;
    e.token   = N'(1) << ptr;
    e.busy    = (owner >= 0) || in_gap;
    e.timeout = to_flag;
    e.hold    = HOLD_W'(age);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the model's response.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rs;
    model_step(r, d, rs);
    q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("token", 32'(token), 32'(e.token));
        check("busy", 32'(busy), 32'(e.busy));
        check("timeout", 32'(timeout), 32'(e.timeout));
        check("hold_cnt", 32'(hold_cnt), 32'(e.hold));
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic         rs;
    req   = '0;
    done  = '0;
    rst_n = 1'b0;

    // Reset with all requests high.
    step(4'b1111, '0, 1'b0);
    step(4'b1111, '0, 1'b0);

    // Fairness: each winner releases on its third grant cycle.
    repeat (28) begin
      d = (owner >= 0 && age == 2) ? (N'(1) << owner) : '0;
      step(4'b1111, d, 1'b1);
    end

    // Timeout: single requester never releases.
    step('0, '0, 1'b0);
    repeat (16) step(4'b0010, '0, 1'b1);

    // Coincident release: done lands on the hold-limit cycle.
    step('0, '0, 1'b0);
    repeat (22) begin
      d = (owner >= 0 && age == HOLD_MAX - 1) ? (N'(1) << owner) : '0;
      step(4'b0010, d, 1'b1);
    end

    // Request drop mid-grant, with stray done on the other bits throughout.
    step('0, '0, 1'b0);
    repeat (14) begin
      r = (owner == 2 && age == 3) ? 4'b0000 : 4'b0100;
      step(r, 4'b1011, 1'b1);
    end

    // Reset mid-grant once gnt=0100 and hold_cnt=3.
    step('0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (owner == 2 && age == 3) break;
      step(4'b0100, '0, 1'b1);
    end
    step(4'b0100, '0, 1'b0);
    repeat (4) step(4'b0100, '0, 1'b1);

    // Random traffic.
    repeat (3000) begin
      r  = N'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if (owner >= 0 && $urandom_range(0, 7) == 0) d = N'(1) << owner;
      rs = ($urandom_range(0, 199) != 0);
      step(r, d, rs);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
